ctrl_sequencer: RTL and testbench

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

---
 rtl/defines_pkg.sv | 18 +
 rtl/ctrl_sequencer.sv | 129 ++++++++++++
 tb/tb_ctrl_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/defines_pkg.sv
// defines_pkg: shared types for the control sequencer.
// Provides the sequencer state enum and a helper that classifies states as busy.
package defines_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PAD,
        S_READY,
        S_START,
        S_RUN
    } seq_state_t;

    function automatic logic is_busy(seq_state_t s);
        return !(s == S_IDLE || s == S_READY);
    endfunction

endpackage

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: loads a CTRL_DEPTH-word schedule into a buffer controller and runs it.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   load_req, cfg_valid, cfg_data   schedule load request and host word stream
//   cfg_ready                       word accepted this cycle
//   run_req, iter_count, abort      execution request, iterations (0 = forever), early stop
//   ctrl_in, load_ctrl              controller write data / write strobe
//   start_ctrl, stop_ctrl           controller run start / stop strobes
//   loaded, busy, done, iters_done  status
module ctrl_sequencer
    import defines_pkg::*;
#(
    parameter int CTRL_WIDTH = 24,
    parameter int CTRL_DEPTH = 48,
    parameter int ITER_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_req,
    input  logic                  cfg_valid,
    input  logic [CTRL_WIDTH-1:0] cfg_data,
    output logic                  cfg_ready,
    input  logic                  run_req,
    input  logic [ITER_W-1:0]     iter_count,
    input  logic                  abort,
    output logic [CTRL_WIDTH-1:0] ctrl_in,
    output logic                  load_ctrl,
    output logic                  start_ctrl,
    output logic                  stop_ctrl,
    output logic                  loaded,
    output logic                  busy,
    output logic                  done,
    output logic [ITER_W-1:0]     iters_done
);

    localparam int CW = $clog2(CTRL_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(CTRL_DEPTH - 1);

    seq_state_t        state_q;
    logic [CW-1:0]     wcnt_q;
    logic [CW-1:0]     phase_q;
    logic [ITER_W-1:0] count_q;
    logic [ITER_W-1:0] iters_q;
    logic              loaded_q;
    logic              done_q;
    logic              abort_pend_q;
    logic              hs;
    logic              last_iter;

    assign cfg_ready  = state_q == S_LOAD;
    assign hs         = cfg_valid & cfg_ready;
    // PAD writes zeros so the controller write pointer wraps back to 0.
    assign load_ctrl  = hs | (state_q == S_PAD);
    assign ctrl_in    = (state_q == S_LOAD) ? cfg_data : '0;
    assign start_ctrl = state_q == S_START;
    // A zero count means run forever, so it never matches.
    assign last_iter  = (count_q != '0) && (ITER_W'(iters_q + 1'b1) == count_q);
    // Stopping only at the last phase leaves the controller read pointer at 0.
    assign stop_ctrl  = (state_q == S_RUN) && (phase_q == LAST) && (last_iter || abort_pend_q);
    assign loaded     = loaded_q;
    assign busy       = is_busy(state_q);
    assign done       = done_q;
    assign iters_done = iters_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wcnt_q       <= '0;
            phase_q      <= '0;
            count_q      <= '0;
            iters_q      <= '0;
            loaded_q     <= 1'b0;
            done_q       <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_READY: begin
                    if (load_req) begin
                        state_q  <= S_LOAD;
                        wcnt_q   <= '0;
                        loaded_q <= 1'b0;
                    end else if (state_q == S_READY && run_req) begin
                        state_q      <= S_START;
                        count_q      <= iter_count;
                        iters_q      <= '0;
                        phase_q      <= '0;
                        abort_pend_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    // Completion wins over a coincident abort: the schedule is whole.
                    if (hs && wcnt_q == LAST) begin
                        state_q  <= S_READY;
                        wcnt_q   <= '0;
                        loaded_q <= 1'b1;
                    end else begin
                        if (hs) wcnt_q <= wcnt_q + 1'b1;
                        if (abort) state_q <= S_PAD;
                    end
                end
                S_PAD: begin
                    if (wcnt_q == LAST) begin
                        state_q <= S_IDLE;
                        wcnt_q  <= '0;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                S_START: begin
                    state_q <= S_RUN;
                    phase_q <= CW'(1);
                    if (abort) abort_pend_q <= 1'b1;
                end
                S_RUN: begin
                    if (abort) abort_pend_q <= 1'b1;
                    phase_q <= (phase_q == LAST) ? '0 : phase_q + 1'b1;
                    if (phase_q == LAST && iters_q != '1) iters_q <= iters_q + 1'b1;
                    if (stop_ctrl) begin
                        state_q <= S_READY;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: scoreboard bench for ctrl_sequencer at CTRL_DEPTH=48.
module tb_ctrl_sequencer;

    localparam int W  = 24;
    localparam int D  = 48;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_req;
    logic          cfg_valid;
    logic [W-1:0]  cfg_data;
    logic          cfg_ready;
    logic          run_req;
    logic [IW-1:0] iter_count;
    logic          abort;
    logic [W-1:0]  ctrl_in;
    logic          load_ctrl;
    logic          start_ctrl;
    logic          stop_ctrl;
    logic          loaded;
    logic          busy;
    logic          done;
    logic [IW-1:0] iters_done;

    ctrl_sequencer #(.CTRL_WIDTH(W), .CTRL_DEPTH(D), .ITER_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .cfg_valid(cfg_valid),
        .cfg_data(cfg_data), .cfg_ready(cfg_ready), .run_req(run_req),
        .iter_count(iter_count), .abort(abort), .ctrl_in(ctrl_in),
        .load_ctrl(load_ctrl), .start_ctrl(start_ctrl), .stop_ctrl(stop_ctrl),
        .loaded(loaded), .busy(busy), .done(done), .iters_done(iters_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_load = 0, n_pad = 0, n_start = 0, n_stop = 0, n_done = 0, n_both = 0;
    int start_cyc = 0, stop_cyc = 0, done_cyc = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: every controller write pops the next expected word.
    always @(negedge clk) begin
        if (rst_n) begin
            if (load_ctrl) begin
                n_load++;
                if (!cfg_ready) n_pad++;
                if (exp_q.size() == 0) check("ctrl_extra", 1, 0);
                else check("ctrl_in", 64'(ctrl_in), 64'(exp_q.pop_front()));
            end
            if (start_ctrl) begin n_start++; start_cyc = cyc; end
            if (stop_ctrl) begin n_stop++; stop_cyc = cyc; end
            if (done) begin n_done++; done_cyc = cyc; end
            if (start_ctrl && stop_ctrl) n_both++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n, input bit bubbles);
        for (int i = 0; i < n; i++) begin
            while (bubbles && $urandom_range(0, 3) == 0) begin
                cfg_valid = 1'b0;
                tick();
            end
            cfg_valid = 1'b1;
            cfg_data  = W'($urandom());
            exp_q.push_back(cfg_data);
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic run(input int iters);
        iter_count = IW'(iters);
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int d0 = n_done;
        for (int i = 0; i < 400 && n_done == d0; i++) tick();
        check(tag, 64'(n_done - d0), 1);
    endtask

    initial begin
        int l0, s0, st0, p0;
        rst_n = 1'b0; load_req = 0; cfg_valid = 0; cfg_data = '0;
        run_req = 0; iter_count = '0; abort = 0;
        #3;
        check("rst_busy", busy, 0);
        check("rst_loaded", loaded, 0);
        check("rst_strobes", {load_ctrl, start_ctrl, stop_ctrl, done, cfg_ready}, 0);
        check("rst_ctrl_in", ctrl_in, 0);
        check("rst_iters", iters_done, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Full load with random bubbles.
        pulse_load();
        check("load_ready", cfg_ready, 1);
        check("load_busy", busy, 1);
        push_words(D - 1, 1'b1);
        check("loaded_early", loaded, 0);
        push_words(1, 1'b0);
        check("loaded_set", loaded, 1);
        check("ready_drop", cfg_ready, 0);
        tick();
        check("load_count", n_load, D);
        check("load_q_empty", exp_q.size(), 0);

        // Two iterations.
        s0 = n_stop;
        run(2);
        wait_done("done_run2");
        check("run2_stop_at", stop_cyc - start_cyc, 95);
        check("run2_done_at", done_cyc - start_cyc, 96);
        check("run2_stop_n", n_stop - s0, 1);
        check("run2_iters", iters_done, 2);
        check("run2_idle", busy, 0);

        // Endless run, aborted mid-iteration.
        s0 = n_stop;
        run(0);
        repeat (10) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("done_abort");
        check("abort_stop_at", stop_cyc - start_cyc, 47);
        check("abort_stop_n", n_stop - s0, 1);
        check("abort_iters", iters_done, 1);
        check("abort_loaded", loaded, 1);

        // load_req during RUN is ignored.
        l0 = n_load;
        run(1);
        repeat (5) tick();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        wait_done("done_run1");
        check("run1_stop_at", stop_cyc - start_cyc, 47);
        check("run1_iters", iters_done, 1);
        check("run1_no_load", n_load - l0, 0);
        check("run1_loaded", loaded, 1);

        // Abort a load after 20 words: 28 zero pad writes, then IDLE.
        pulse_load();
        check("reload_cleared", loaded, 0);
        push_words(20, 1'b0);
        p0 = n_pad;
        abort = 1'b1;
        for (int i = 0; i < D - 20; i++) exp_q.push_back('0);
        tick();
        abort = 1'b0;
        for (int i = 0; i < 100 && busy; i++) tick();
        check("pad_cycles", n_pad - p0, D - 20);
        check("pad_q_empty", exp_q.size(), 0);
        check("pad_loaded", loaded, 0);
        check("pad_idle", busy, 0);

        // run_req in IDLE is ignored.
        st0 = n_start;
        l0 = n_load;
        run(3);
        repeat (3) tick();
        check("idle_run_busy", busy, 0);
        check("idle_run_strobes", n_start - st0 + n_load - l0, 0);

        // Reset in the middle of a run.
        pulse_load();
        push_words(D, 1'b1);
        tick();
        run(0);
        repeat (20) tick();
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_loaded", loaded, 0);
        check("mid_rst_strobes", {load_ctrl, start_ctrl, stop_ctrl, done, cfg_ready}, 0);
        check("mid_rst_iters", iters_done, 0);
        tick();
        rst_n = 1'b1;
        st0 = n_start;
        run(1);
        repeat (3) tick();
        check("post_rst_idle", busy, 0);
        check("post_rst_nostart", n_start - st0, 0);
        check("never_both", n_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
